// File: rtl/pe_mc_drain.sv
// Output-stationary systolic PE with CH column channels, saturating or wrapping
// accumulators, and a serial drain chain that unloads results down the column.
module pe_mc_drain #(
  parameter int WIDTH = 8,
  parameter int CH    = 2,
  parameter int ACC_W = 2*WIDTH+4,
  parameter int SAT   = 1
) (
  input  logic                  clk,
  input  logic                  _rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  drain_start,
  input  logic [WIDTH-1:0]      in_left,
  input  logic [CH*WIDTH-1:0]   in_above,
  input  logic [ACC_W-1:0]      drain_in,
  input  logic                  drain_in_valid,
  output logic [WIDTH-1:0]      out_right,
  output logic [CH*WIDTH-1:0]   out_bottom,
  output logic [CH*ACC_W-1:0]   acc,
  output logic [ACC_W-1:0]      drain_out,
  output logic                  drain_out_valid,
  output logic                  busy,
  output logic [CH-1:0]         ovf,
  output logic                  drain_err
);

  localparam int IDX_W = $clog2(CH+1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACC, DRAIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;

  logic signed [2*WIDTH-1:0] prod [CH];
  logic signed [ACC_W-1:0]   pext [CH];
  logic signed [ACC_W:0]     sum  [CH];
  logic [CH*ACC_W-1:0]       acc_sum;
  logic [CH*ACC_W-1:0]       acc_load;
  logic [CH-1:0]             ovf_now;
  logic [ACC_W-1:0]          drain_word;

  // Per-channel MAC: sum is one bit wider so overflow is visible as a
  // disagreement between the top two bits.
  always_comb begin
    acc_sum  = '0;
    acc_load = '0;
    ovf_now  = '0;
    for (int k = 0; k < CH; k++) begin
      prod[k] = $signed(in_left) * $signed(in_above[k*WIDTH +: WIDTH]);
      pext[k] = prod[k];
      sum[k]  = $signed({acc[k*ACC_W+ACC_W-1], acc[k*ACC_W +: ACC_W]})
              + $signed({pext[k][ACC_W-1], pext[k]});
      acc_load[k*ACC_W +: ACC_W] = pext[k];
      ovf_now[k] = sum[k][ACC_W] ^ sum[k][ACC_W-1];
      if (ovf_now[k] && (SAT != 0))
        acc_sum[k*ACC_W +: ACC_W] = sum[k][ACC_W] ? ACC_MIN : ACC_MAX;
      else
        acc_sum[k*ACC_W +: ACC_W] = sum[k][ACC_W-1:0];
    end
  end

  always_comb begin
    drain_word = '0;
    for (int k = 0; k < CH; k++)
      if (IDX_W'(k) == idx) drain_word = acc[k*ACC_W +: ACC_W];
  end

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      state           <= ACC;
      idx             <= '0;
      out_right       <= '0;
      out_bottom      <= '0;
      acc             <= '0;
      drain_out       <= '0;
      drain_out_valid <= 1'b0;
      busy            <= 1'b0;
      ovf             <= '0;
      drain_err       <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (drain_start) begin
            // Channel 0 leaves on the accepting edge so words follow with no bubble;
            // an upstream word arriving now has nowhere to go and is flagged.
            state           <= DRAIN;
            busy            <= 1'b1;
            idx             <= IDX_W'(1);
            drain_out       <= acc[ACC_W-1:0];
            drain_out_valid <= 1'b1;
            if (drain_in_valid) drain_err <= 1'b1;
          end else begin
            drain_out       <= drain_in;
            drain_out_valid <= drain_in_valid;
            if (enable) begin
              out_right  <= in_left;
              out_bottom <= in_above;
            end
            if (clear) begin
              acc       <= enable ? acc_load : '0;
              ovf       <= '0;
              drain_err <= 1'b0;
            end else if (enable) begin
              acc <= acc_sum;
              ovf <= ovf | ovf_now;
            end
          end
        end
        DRAIN: begin
          if (drain_in_valid) drain_err <= 1'b1;
          if (idx == IDX_LAST) begin
            state           <= ACC;
            busy            <= 1'b0;
            idx             <= '0;
            acc             <= '0;
            ovf             <= '0;
            drain_out       <= '0;
            drain_out_valid <= 1'b0;
          end else begin
            drain_out       <= drain_word;
            drain_out_valid <= 1'b1;
            idx             <= idx + IDX_W'(1);
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mc_drain.sv
// Directed bench for pe_mc_drain: a scoreboard queue holds expected drain words
// and a negedge monitor pops them; register state is checked after each edge.
module tb_pe_mc_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: default parameters (ACC_W = 20)
  logic        enable = 0, clear = 0, drain_start = 0, drain_in_valid = 0;
  logic [7:0]  in_left = '0;
  logic [15:0] in_above = '0;
  logic [19:0] drain_in = '0;
  logic [7:0]  out_right;
  logic [15:0] out_bottom;
  logic [39:0] acc;
  logic [19:0] drain_out;
  logic        drain_out_valid, busy, drain_err;
  logic [1:0]  ovf;

  pe_mc_drain dut (
    .clk(clk), ._rst(rst), .enable(enable), .clear(clear), .drain_start(drain_start),
    .in_left(in_left), .in_above(in_above), .drain_in(drain_in),
    .drain_in_valid(drain_in_valid), .out_right(out_right), .out_bottom(out_bottom),
    .acc(acc), .drain_out(drain_out), .drain_out_valid(drain_out_valid),
    .busy(busy), .ovf(ovf), .drain_err(drain_err)
  );

  // Narrow-accumulator instances sharing one stimulus: saturating and wrapping
  logic        s_en = 0;
  logic [7:0]  s_left = '0;
  logic [15:0] s_above = '0;
  logic        zero_b = 1'b0;
  logic [15:0] zero_w = '0;
  logic [7:0]  sat_or, wrp_or;
  logic [15:0] sat_ob, wrp_ob, sat_do, wrp_do;
  logic [31:0] sat_acc, wrp_acc;
  logic        sat_dov, wrp_dov, sat_busy, wrp_busy, sat_err, wrp_err;
  logic [1:0]  sat_ovf, wrp_ovf;

  pe_mc_drain #(.WIDTH(8), .CH(2), .ACC_W(16), .SAT(1)) dut_sat (
    .clk(clk), ._rst(rst), .enable(s_en), .clear(zero_b), .drain_start(zero_b),
    .in_left(s_left), .in_above(s_above), .drain_in(zero_w), .drain_in_valid(zero_b),
    .out_right(sat_or), .out_bottom(sat_ob), .acc(sat_acc), .drain_out(sat_do),
    .drain_out_valid(sat_dov), .busy(sat_busy), .ovf(sat_ovf), .drain_err(sat_err)
  );

  pe_mc_drain #(.WIDTH(8), .CH(2), .ACC_W(16), .SAT(0)) dut_wrap (
    .clk(clk), ._rst(rst), .enable(s_en), .clear(zero_b), .drain_start(zero_b),
    .in_left(s_left), .in_above(s_above), .drain_in(zero_w), .drain_in_valid(zero_b),
    .out_right(wrp_or), .out_bottom(wrp_ob), .acc(wrp_acc), .drain_out(wrp_do),
    .drain_out_valid(wrp_dov), .busy(wrp_busy), .ovf(wrp_ovf), .drain_err(wrp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  function automatic logic [63:0] sx20(input logic [19:0] v);
    return {{44{v[19]}}, v};
  endfunction
  function automatic logic [63:0] sx16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction
  function automatic logic [63:0] sx8(input logic [7:0] v);
    return {{56{v[7]}}, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] l, input logic [7:0] a1, input logic [7:0] a0);
    in_left  = l;
    in_above = {a1, a0};
  endtask

  // Scoreboard monitor: every valid drain word must match the queue head
  always @(negedge clk) begin
    if (drain_out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_unexpected: got %0d expected no word at %0t",
                 $signed(drain_out), $time);
      end else begin
        check("drain_word", sx20(drain_out), sx20(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;

    // Saturation vs wrap, -128 * -128 = 16384 per cycle into 16-bit accumulators
    s_en = 1; s_left = 8'h80; s_above = {8'h00, 8'h80};
    step();
    check("sat_c1_acc0", sx16(sat_acc[15:0]), 64'(16384));
    check("sat_c1_ovf",  64'(sat_ovf), 64'(0));
    check("wrp_c1_acc0", sx16(wrp_acc[15:0]), 64'(16384));
    step();
    check("sat_c2_acc0", sx16(sat_acc[15:0]), 64'(32767));
    check("sat_c2_ovf",  64'(sat_ovf), 64'(1));
    check("wrp_c2_acc0", sx16(wrp_acc[15:0]), 64'(-32768));
    check("wrp_c2_ovf",  64'(wrp_ovf), 64'(1));
    step();
    check("sat_c3_acc0", sx16(sat_acc[15:0]), 64'(32767));
    check("sat_c3_acc1", sx16(sat_acc[31:16]), 64'(0));
    check("wrp_c3_acc0", sx16(wrp_acc[15:0]), 64'(-16384));
    check("wrp_c3_ovf",  64'(wrp_ovf), 64'(1));
    s_en = 0;

    // Pass-through and first product
    enable = 1; set_ops(8'd3, -8'sd2, 8'd5);
    step();
    check("t1_out_right", sx8(out_right), 64'(3));
    check("t1_out_b0",    sx8(out_bottom[7:0]), 64'(5));
    check("t1_out_b1",    sx8(out_bottom[15:8]), 64'(-2));
    check("t1_acc0",      sx20(acc[19:0]), 64'(15));
    check("t1_acc1",      sx20(acc[39:20]), 64'(-6));

    // Asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    check("rst_out_right", 64'(out_right), 64'(0));
    check("rst_out_bottom", 64'(out_bottom), 64'(0));
    check("rst_acc", 64'(acc), 64'(0));
    check("rst_sat_acc", 64'(sat_acc), 64'(0));
    check("rst_sat_ovf", 64'(sat_ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    // Accumulate, hold, clear-and-load
    step();
    check("t2_acc0_a", sx20(acc[19:0]), 64'(15));
    check("t2_acc1_a", sx20(acc[39:20]), 64'(-6));
    set_ops(8'd4, 8'd1, 8'd1);
    step();
    check("t2_acc0_b", sx20(acc[19:0]), 64'(19));
    check("t2_acc1_b", sx20(acc[39:20]), 64'(-2));
    enable = 0; set_ops(8'd9, 8'd9, 8'd9);
    step();
    step();
    check("t2_hold_acc0", sx20(acc[19:0]), 64'(19));
    check("t2_hold_acc1", sx20(acc[39:20]), 64'(-2));
    check("t2_hold_right", sx8(out_right), 64'(4));
    enable = 1; clear = 1; set_ops(8'd1, 8'd1, 8'd1);
    step();
    check("t2_clr_acc0", sx20(acc[19:0]), 64'(1));
    check("t2_clr_acc1", sx20(acc[39:20]), 64'(1));

    // Drain of acc = {ch1=7, ch0=9} with conflicting inputs during DRAIN
    set_ops(8'd1, 8'd7, 8'd9);
    step();
    check("t4_acc0", sx20(acc[19:0]), 64'(9));
    check("t4_acc1", sx20(acc[39:20]), 64'(7));
    enable = 0; clear = 0; drain_start = 1;
    exp_q.push_back(20'd9);
    exp_q.push_back(20'd7);
    step();
    check("t4_busy_w0", 64'(busy), 64'(1));
    check("t4_valid_w0", 64'(drain_out_valid), 64'(1));
    drain_start = 0; enable = 1; clear = 1; set_ops(8'd5, 8'd5, 8'd5);
    drain_in = 20'd42; drain_in_valid = 1;
    step();
    check("t4_busy_w1", 64'(busy), 64'(1));
    check("t4_valid_w1", 64'(drain_out_valid), 64'(1));
    check("t5_right_hold", sx8(out_right), 64'(1));
    check("t5_acc0_hold", sx20(acc[19:0]), 64'(9));
    check("t5_drain_err", 64'(drain_err), 64'(1));
    step();
    check("t4_busy_end", 64'(busy), 64'(0));
    check("t4_valid_end", 64'(drain_out_valid), 64'(0));
    check("t4_acc_zero", 64'(acc), 64'(0));
    check("t5_bottom_hold", 64'(out_bottom), 64'({8'd7, 8'd9}));
    check("t5_err_sticky", 64'(drain_err), 64'(1));

    // Pass-through of an upstream word in ACC
    enable = 0; clear = 0;
    exp_q.push_back(20'd42);
    step();
    check("t5_pass_valid", 64'(drain_out_valid), 64'(1));
    drain_in_valid = 0;
    step();
    check("t5_pass_done", 64'(drain_out_valid), 64'(0));
    check("t5_err_kept", 64'(drain_err), 64'(1));
    clear = 1;
    step();
    check("t5_err_cleared", 64'(drain_err), 64'(0));
    clear = 0;

    // Reset in the middle of a drain
    enable = 1; clear = 1; set_ops(8'd1, 8'd3, 8'd4);
    step();
    enable = 0; clear = 0; drain_start = 1;
    exp_q.push_back(20'd4);
    step();
    drain_start = 0;
    check("t6_busy_w0", 64'(busy), 64'(1));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(drain_out_valid), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_acc", 64'(acc), 64'(0));
    #2 rst = 1'b0;
    step();
    step();
    step();
    check("t6_busy_after", 64'(busy), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_mc_drain.md
Name: pe_mc_drain

Overview:
- Output-stationary systolic processing element for the self-attention matrix engine.
- Generalises the two-column PE to CH column channels, with a parametrised accumulator width and saturating or wrapping arithmetic.
- Adds an in-array drain path: each PE serially shifts its accumulators down a column chain, so results are unloaded without a wide readout bus.
- Sits in the NxM PE grid between the row-operand feeders (left) and column-operand feeders (top).

Parameters:
- WIDTH, 8: operand width, signed two's complement.
- CH, 2: number of column channels / accumulators per PE (>=1).
- ACC_W, 2*WIDTH+4: accumulator width (>=2*WIDTH).
- SAT, 1: 1 = saturate on overflow; 0 = wrap.

Ports:
- clk  in  1  rising-edge clock.
- _rst  in  1  asynchronous, active-high reset (1 = reset asserted).
- enable  in  1  advance operands and accumulate.
- clear  in  1  synchronous accumulator clear.
- drain_start  in  1  begin serial unload of own accumulators.
- in_left  in  WIDTH  row operand.
- in_above  in  CH*WIDTH  column operands; channel k = bits [k*WIDTH +: WIDTH].
- drain_in  in  ACC_W  drain data from the PE above.
- drain_in_valid  in  1  qualifies drain_in.
- out_right  out  WIDTH  registered row operand to the right.
- out_bottom  out  CH*WIDTH  registered column operands downward.
- acc  out  CH*ACC_W  accumulator values, same packing as in_above.
- drain_out  out  ACC_W  drain data to the PE below.
- drain_out_valid  out  1  qualifies drain_out.
- busy  out  1  1 while in DRAIN.
- ovf  out  CH  sticky per-channel overflow flags.
- drain_err  out  1  sticky flag: drain_in_valid arrived during DRAIN.

Behaviour:
- Reset (_rst=1, async):
  - All outputs and accumulators = 0; state = ACC; drain index = 0.
  - Reset mid-drain aborts the drain; no partial output follows.
- States: ACC (compute/pass-through) and DRAIN (own unload).
- ACC, enable=1:
  - out_right <= in_left; out_bottom[k] <= in_above[k].
  - acc[k] <= acc[k] + in_left*in_above[k].
- ACC, enable=0: operand outputs and acc hold.
- Arithmetic:
  - Product is signed 2*WIDTH, sign-extended to ACC_W; sum is formed at ACC_W+1 bits.
  - Overflow: SAT=1 clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1); SAT=0 keeps the low ACC_W bits.
  - Either way, overflow sets ovf[k].
- clear=1 in ACC:
  - acc[k] <= 0, or acc[k] <= product if enable=1 the same cycle (clear-and-load).
  - ovf <= 0; drain_err <= 0.
  - clear has priority over plain accumulate.
- ACC pass-through: drain_out <= drain_in; drain_out_valid <= drain_in_valid. Registered, 1-cycle latency per PE.
- drain_start=1 in ACC:
  - Enter DRAIN next cycle; busy=1.
  - enable, clear and drain_start in that cycle are ignored (drain wins).
- DRAIN cycle i (i = 0..CH-1):
  - drain_out <= acc[i]; drain_out_valid <= 1; channel 0 first.
  - After the cycle with i=CH-1: acc <= 0, ovf <= 0, state <= ACC, busy <= 0.
  - First drain word is valid the cycle after drain_start; CH consecutive valid words; no bubble.
- During DRAIN:
  - enable, clear and drain_start are ignored; operand outputs hold.
  - A drain_in_valid=1 word is dropped and sets drain_err. drain_err is sticky until clear or reset.
- A drain_start on the cycle busy falls is accepted; the next drain begins the following cycle with zeros.

Test Plan:
1. Reset/pass-through: default params, _rst pulse mid-cycle. All outputs are 0 asynchronously. Then enable=1, in_left=3, in_above={ch1=-2, ch0=5}: next cycle out_right=3, out_bottom={-2,5}, acc={-6,15}.
2. Accumulate/hold/clear: feed (3,{-2,5}), (4,{1,1}), enable=0 for 2 cycles, then (1,{1,1}) with clear=1. acc goes {-6,15} -> {-2,19}, holds {-2,19}, then becomes {1,1}.
3. Saturation: ACC_W=16, SAT=1, in_left=-128, in_above ch0=-128, three enabled cycles. acc0 = 16384, then 32767 with ovf[0]=1, then stays 32767. Repeat with SAT=0: second cycle gives acc0 = -32768, ovf[0]=1.
4. Drain: CH=2, acc={7,9}, drain_start=1. Next two cycles drain_out = 9 then 7, valid=1, busy=1. Following cycle acc={0,0}, busy=0, valid=0.
5. Drain conflicts: during DRAIN assert enable=1, clear=1 and drain_in_valid=1 (drain_in=42). Operands and acc are unaffected, 42 never appears on drain_out, drain_err=1. Then drain_in=42, valid=1 in ACC: drain_out=42, valid=1 one cycle later.
6. Reset mid-drain: assert _rst after the first drain word. drain_out_valid=0, busy=0 and acc=0 immediately; no second word appears after release.
